baudgen_frac: RTL and testbench
===============================

Name: baudgen_frac

Overview:
- Parametrised fractional baud-rate generator; next generation of the single-divider toggle generator.
- Produces a one-cycle oversample tick from a programmable integer.fraction divisor of i_Pclk.
- Derives per-bit framing strobes (mid-bit sample, bit end) and a 50 % bit clock, with safe divisor reload and enable control.
- Sits between the register/config logic and the USRT transmit/receive shifters.

Parameters:
- CNT_W, 16, width of integer divisor and period counter.
- FRAC_W, 4, width of fractional divisor and phase accumulator; fraction = i_Div_Frac / 2^FRAC_W.
- OVERSAMPLE, 16, ticks per bit; even, >= 4.
- DEFAULT_DIV, 16, integer divisor loaded at reset; fraction resets to 0.

Ports:
- i_Pclk  in  1  system clock; all logic on posedge.
- i_Rst  in  1  asynchronous, active-high reset.
- i_En  in  1  generator run enable.
- i_Load  in  1  one-cycle pulse; capture i_Div_Int/i_Div_Frac into shadow registers.
- i_Div_Int  in  CNT_W  integer divisor, in i_Pclk cycles per tick.
- i_Div_Frac  in  FRAC_W  fractional divisor.
- o_Tick  out  1  one-cycle oversample tick.
- o_Mid_Stb  out  1  one-cycle pulse at bit midpoint.
- o_Bit_Stb  out  1  one-cycle pulse at bit end.
- o_Bclk  out  1  bit-rate clock: 0 in first half of bit, 1 in second half.
- o_Bad_Div  out  1  active divisor integer part is 0.

Behaviour:
- Reset (async, active-high):
  - All outputs, counters and accumulator go to 0.
  - Active divisor = DEFAULT_DIV.0; shadow divisor = DEFAULT_DIV.0; load-pending flag = 0.
- All outputs are registered.
- State: IDLE (i_En=0) and RUN. Transitions:
  - IDLE->RUN on i_En=1.
  - RUN->IDLE on i_En=0 (immediate).
- IDLE behaviour:
  - Period counter, sub-bit counter and accumulator are held at 0; all strobes and o_Bclk are 0.
  - i_Load in IDLE updates both shadow and active divisor on the next edge.
- Period: each tick period k lasts P_k = Div_Int + c_k cycles.
  - c_k is the carry out of acc + Div_Frac (FRAC_W+1-bit add), evaluated at the start of period k.
  - acc takes the sum modulo 2^FRAC_W.
- Tick timing: with i_En first sampled high at edge 0, the first o_Tick is high for the cycle following edge P_0, then every P_k cycles.
  - Div_Int=1 with frac=0 gives o_Tick continuously high.
- Sub-bit counter: 0..OVERSAMPLE-1, advances on each tick, wraps to 0.
  - o_Mid_Stb asserts with the tick that moves the counter to OVERSAMPLE/2.
  - o_Bit_Stb asserts with the tick that wraps OVERSAMPLE-1 -> 0.
  - o_Bclk = 1 while the counter is >= OVERSAMPLE/2; it rises coincident with o_Mid_Stb.
- Load while RUN:
  - i_Load captures into shadow and sets the pending flag.
  - Pending is applied at the next bit boundary; the period after o_Bit_Stb uses the new divisor.
  - The accumulator is not cleared on load.
  - Load coincident with the bit-boundary edge: the new value applies from that boundary.
  - A second load before the boundary overwrites the shadow (last one wins).
- Bad divisor:
  - Active Div_Int == 0 -> o_Bad_Div=1; counters freeze and no strobes are produced while RUN.
  - Recovery is only via a load with a nonzero value; in RUN it takes effect immediately, since there is no boundary to wait for.
- Enable drop mid-bit: counters and accumulator clear on the next edge; the next enable restarts a full bit from phase 0.
- Widths: no overflow; the period counter compares against P_k - 1, and P_k needs CNT_W+1 bits.

Test Plan:
- Div=4.0, OS=16, En from cycle 0 -> o_Tick every 4 cycles; o_Mid_Stb at tick 8; o_Bit_Stb every 64 cycles; o_Bclk low 32 / high 32 cycles.
- Div=4.8/16 (frac=8) -> periods alternate 4,5; 16 ticks = 72 cycles exactly; no drift over 10 bits (720 cycles).
- Div=4.0 running, load 8.0 at cycle 20 -> remainder of bit 0 stays 4-cycle ticks; first tick after o_Bit_Stb at cycle 64 arrives 8 cycles later.
- Load 0 -> o_Bad_Div=1 after the applying edge, no strobes for 100 cycles; load 2.0 -> o_Bad_Div=0, ticks resume every 2 cycles.
- i_En dropped at cycle 37, re-raised at 50 -> all outputs 0 from cycle 38; first tick at 50+Div; sub-bit phase restarts at 0.
- Assert i_Rst asynchronously mid-bit (between clock edges) -> outputs 0 immediately; after release with En=1, first tick after DEFAULT_DIV (16) cycles.

Source files
------------

// File: rtl/baudgen_frac.sv
// baudgen_frac -- fractional baud-rate generator.
//
// Generates a one-cycle oversample tick from an integer.fraction divisor of
// i_Pclk. Each tick period lasts Div_Int + carry cycles, where the carry comes
// from a FRAC_W-bit phase accumulator. From the tick stream it derives
// per-bit strobes (mid-bit, bit end) and a 50 % bit clock. Divisor updates
// are double-buffered so that a bit in flight is never distorted.
//
// Ports:
//   i_Pclk      system clock, rising edge
//   i_Rst       asynchronous active-high reset
//   i_En        run enable; low holds the generator idle and cleared
//   i_Load      one-cycle pulse, capture i_Div_Int / i_Div_Frac
//   i_Div_Int   integer divisor (i_Pclk cycles per tick)
//   i_Div_Frac  fractional divisor, value / 2^FRAC_W
//   o_Tick      one-cycle oversample tick
//   o_Mid_Stb   one-cycle pulse at bit midpoint
//   o_Bit_Stb   one-cycle pulse at bit end
//   o_Bclk      bit clock, low in first half of bit, high in second half
//   o_Bad_Div   active integer divisor is zero
module baudgen_frac #(
  parameter int CNT_W       = 16,
  parameter int FRAC_W      = 4,
  parameter int OVERSAMPLE  = 16,
  parameter int DEFAULT_DIV = 16
) (
  input  logic              i_Pclk,
  input  logic              i_Rst,
  input  logic              i_En,
  input  logic              i_Load,
  input  logic [CNT_W-1:0]  i_Div_Int,
  input  logic [FRAC_W-1:0] i_Div_Frac,
  output logic              o_Tick,
  output logic              o_Mid_Stb,
  output logic              o_Bit_Stb,
  output logic              o_Bclk,
  output logic              o_Bad_Div
);

  localparam int SUB_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  localparam logic [SUB_W-1:0] SUB_HALF = SUB_W'(OVERSAMPLE / 2);
  localparam logic [SUB_W-1:0] SUB_ONE  = SUB_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  div_int_r, div_int_s;
  logic [FRAC_W-1:0] div_frac_r, div_frac_s;
  logic [CNT_W-1:0]  shd_int_r, shd_int_s;
  logic [FRAC_W-1:0] shd_frac_r, shd_frac_s;
  logic              pend_r, pend_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [SUB_W-1:0]  sub_r, sub_s;
  logic [FRAC_W-1:0] acc_r, acc_s;
  logic              tick_r, tick_s;
  logic              mid_r, mid_s;
  logic              bit_r, bit_s;
  logic              bclk_r, bclk_s;
  logic              bad_r, bad_s;

  logic [FRAC_W:0]   sum_s;
  logic [CNT_W:0]    per_m1_s;
  logic              run_s;
  logic              div_zero_s;
  logic              end_s;
  logic              wrap_s;
  logic              imm_s;

  // Period arithmetic: carry of acc + frac lengthens the current period by one.
  // The period is compared as P-1 in CNT_W+1 bits so Div_Int=max plus carry fits.
  assign sum_s      = {1'b0, acc_r} + {1'b0, div_frac_r};
  assign per_m1_s   = {1'b0, div_int_r} + {CNT_ZERO, sum_s[FRAC_W]} - {CNT_ZERO, 1'b1};
  assign run_s      = (state_r == ST_RUN) && i_En;
  assign div_zero_s = (div_int_r == CNT_ZERO);
  assign end_s      = run_s && !div_zero_s && ({1'b0, cnt_r} == per_m1_s);
  assign wrap_s     = end_s && (sub_r == SUB_LAST);
  // Loads bypass the shadow when nothing is running or the divisor is stuck at 0.
  assign imm_s      = !run_s || div_zero_s;

  // Enable FSM next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_En) state_s = ST_RUN;
        else      state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (i_En) state_s = ST_RUN;
        else      state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Enable FSM state register.
  always_ff @(posedge i_Pclk or posedge i_Rst) begin
    if (i_Rst) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Counter, strobe and divisor next-value logic.
  always_comb begin
    cnt_s      = cnt_r;
    sub_s      = sub_r;
    acc_s      = acc_r;
    tick_s     = 1'b0;
    mid_s      = 1'b0;
    bit_s      = 1'b0;
    bclk_s     = bclk_r;
    div_int_s  = div_int_r;
    div_frac_s = div_frac_r;
    shd_int_s  = shd_int_r;
    shd_frac_s = shd_frac_r;
    pend_s     = pend_r;

    // The first enabled edge (IDLE->RUN) only arms the generator; counting
    // starts from phase 0 on the following edge.
    if (!run_s) begin
      cnt_s  = CNT_ZERO;
      sub_s  = {SUB_W{1'b0}};
      acc_s  = {FRAC_W{1'b0}};
      bclk_s = 1'b0;
    end else if (div_zero_s) begin
      cnt_s = cnt_r;
    end else if (end_s) begin
      cnt_s  = CNT_ZERO;
      acc_s  = sum_s[FRAC_W-1:0];
      tick_s = 1'b1;
      if (wrap_s) sub_s = {SUB_W{1'b0}};
      else        sub_s = sub_r + SUB_ONE;
      mid_s  = (sub_s == SUB_HALF);
      bit_s  = wrap_s;
      bclk_s = (sub_s >= SUB_HALF);
    end else begin
      cnt_s = cnt_r + CNT_ONE;
    end

    if (i_Load) begin
      shd_int_s  = i_Div_Int;
      shd_frac_s = i_Div_Frac;
    end else begin
      shd_int_s  = shd_int_r;
      shd_frac_s = shd_frac_r;
    end

    // A load landing on the boundary edge applies at once, as does any
    // load while idle or stuck; otherwise it waits for the next bit end.
    if (i_Load && (imm_s || wrap_s)) begin
      div_int_s  = i_Div_Int;
      div_frac_s = i_Div_Frac;
      pend_s     = 1'b0;
    end else if (i_Load) begin
      pend_s = 1'b1;
    end else if (wrap_s && pend_r) begin
      div_int_s  = shd_int_r;
      div_frac_s = shd_frac_r;
      pend_s     = 1'b0;
    end else begin
      pend_s = pend_r;
    end

    bad_s = (div_int_s == CNT_ZERO);
  end

  // Datapath and output registers.
  always_ff @(posedge i_Pclk or posedge i_Rst) begin
    if (i_Rst) begin
      cnt_r      <= CNT_ZERO;
      sub_r      <= {SUB_W{1'b0}};
      acc_r      <= {FRAC_W{1'b0}};
      tick_r     <= 1'b0;
      mid_r      <= 1'b0;
      bit_r      <= 1'b0;
      bclk_r     <= 1'b0;
      bad_r      <= 1'b0;
      div_int_r  <= DIV_RST;
      div_frac_r <= {FRAC_W{1'b0}};
      shd_int_r  <= DIV_RST;
      shd_frac_r <= {FRAC_W{1'b0}};
      pend_r     <= 1'b0;
    end else begin
      cnt_r      <= cnt_s;
      sub_r      <= sub_s;
      acc_r      <= acc_s;
      tick_r     <= tick_s;
      mid_r      <= mid_s;
      bit_r      <= bit_s;
      bclk_r     <= bclk_s;
      bad_r      <= bad_s;
      div_int_r  <= div_int_s;
      div_frac_r <= div_frac_s;
      shd_int_r  <= shd_int_s;
      shd_frac_r <= shd_frac_s;
      pend_r     <= pend_s;
    end
  end

  assign o_Tick    = tick_r;
  assign o_Mid_Stb = mid_r;
  assign o_Bit_Stb = bit_r;
  assign o_Bclk    = bclk_r;
  assign o_Bad_Div = bad_r;

endmodule

// File: tb/tb_baudgen_frac.sv
// Directed self-checking bench for baudgen_frac (CNT_W=16, FRAC_W=4,
// OVERSAMPLE=16, DEFAULT_DIV=16). Edge 0 is the first edge that samples
// i_En high; outputs are sampled 1 ns after each rising edge.
module tb_baudgen_frac;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] dint;
  logic [3:0]  dfrac;
  logic        tick, mid, bstb, bclk, bad;

  int checks   = 0;
  int failures = 0;

  baudgen_frac #(
    .CNT_W(16), .FRAC_W(4), .OVERSAMPLE(16), .DEFAULT_DIV(16)
  ) dut (
    .i_Pclk(clk), .i_Rst(rst), .i_En(en), .i_Load(load),
    .i_Div_Int(dint), .i_Div_Frac(dfrac),
    .o_Tick(tick), .o_Mid_Stb(mid), .o_Bit_Stb(bstb),
    .o_Bclk(bclk), .o_Bad_Div(bad)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Load a divisor while the generator is disabled (applies on that edge).
  task automatic idle_load(input logic [15:0] di, input logic [3:0] df);
    en    = 1'b0;
    load  = 1'b1;
    dint  = di;
    dfrac = df;
    step();
    load  = 1'b0;
  endtask

  // Expected {tick, mid, bit, bclk} for Div=4.0, r edges after the start edge.
  function automatic logic [3:0] exp_div4(input int r);
    logic [3:0] v;
    v[3] = (r > 0) && (r % 4 == 0);
    v[2] = (r > 0) && (r % 64 == 32);
    v[1] = (r > 0) && (r % 64 == 0);
    v[0] = (r % 64) >= 32;
    return v;
  endfunction

  initial begin
    logic [3:0] ev;
    logic       act;
    logic       et;
    int         nxt;
    int         k;

    rst = 1'b1; en = 1'b0; load = 1'b0; dint = 16'd0; dfrac = 4'd0;
    step();
    step();
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_mid",  32'(mid),  32'd0);
    chk("rst_bit",  32'(bstb), 32'd0);
    chk("rst_bclk", 32'(bclk), 32'd0);
    chk("rst_bad",  32'(bad),  32'd0);
    rst = 1'b0;
    step();

    // Test 1: Div=4.0, basic tick / strobe / bclk pattern over two bits.
    idle_load(16'd4, 4'd0);
    en = 1'b1;
    for (int e = 0; e <= 130; e++) begin
      step();
      ev = exp_div4(e);
      chk($sformatf("t1_tick@%0d", e), 32'(tick), 32'(ev[3]));
      chk($sformatf("t1_mid@%0d", e),  32'(mid),  32'(ev[2]));
      chk($sformatf("t1_bit@%0d", e),  32'(bstb), 32'(ev[1]));
      chk($sformatf("t1_bclk@%0d", e), 32'(bclk), 32'(ev[0]));
    end

    // Test 2: Div=4+8/16, periods alternate 4,5; a bit is exactly 72 cycles.
    idle_load(16'd4, 4'd8);
    en  = 1'b1;
    nxt = 4;
    k   = 0;
    for (int e = 0; e <= 721; e++) begin
      step();
      chk($sformatf("t2_tick@%0d", e), 32'(tick), 32'(e == nxt));
      chk($sformatf("t2_bit@%0d", e),  32'(bstb), 32'((e > 0) && (e % 72 == 0)));
      if (e == nxt) begin
        k++;
        nxt += ((k % 2) == 1) ? 5 : 4;
      end
    end

    // Test 3: Div=4.0 running, load 8.0 at edge 20, applied after the bit end at 64.
    idle_load(16'd4, 4'd0);
    en = 1'b1;
    for (int e = 0; e <= 200; e++) begin
      load = (e == 20);
      dint = 16'd8;
      step();
      if (e <= 64) et = (e > 0) && (e % 4 == 0);
      else         et = ((e - 64) % 8 == 0);
      chk($sformatf("t3_tick@%0d", e), 32'(tick), 32'(et));
      chk($sformatf("t3_bit@%0d", e),  32'(bstb), 32'((e == 64) || (e == 192)));
    end
    load = 1'b0;

    // Test 4: load 0 (pending until edge 64), stuck, then load 2.0 at edge 170.
    idle_load(16'd4, 4'd0);
    en = 1'b1;
    for (int e = 0; e <= 200; e++) begin
      load = (e == 10) || (e == 170);
      dint = (e == 170) ? 16'd2 : 16'd0;
      step();
      if (e <= 64)      et = (e > 0) && (e % 4 == 0);
      else if (e < 172) et = 1'b0;
      else              et = ((e - 172) % 2 == 0);
      chk($sformatf("t4_tick@%0d", e), 32'(tick), 32'(et));
      chk($sformatf("t4_bad@%0d", e),  32'(bad),  32'((e >= 64) && (e < 170)));
      chk($sformatf("t4_bit@%0d", e),  32'(bstb), 32'(e == 64));
      chk($sformatf("t4_mid@%0d", e),  32'(mid),  32'((e == 32) || (e == 186)));
    end
    load = 1'b0;

    // Test 5: Div=4.0, enable low for edges 37..49, restart from phase 0 at edge 50.
    idle_load(16'd4, 4'd0);
    for (int e = 0; e <= 130; e++) begin
      en = !((e >= 37) && (e < 50));
      step();
      act = 1'b1;
      if (e <= 36)     ev = exp_div4(e);
      else if (e < 50) begin ev = 4'b0000; act = 1'b0; end
      else             ev = exp_div4(e - 50);
      chk($sformatf("t5_tick@%0d", e), 32'(tick), 32'(ev[3] & act));
      chk($sformatf("t5_mid@%0d", e),  32'(mid),  32'(ev[2] & act));
      chk($sformatf("t5_bit@%0d", e),  32'(bstb), 32'(ev[1] & act));
      chk($sformatf("t5_bclk@%0d", e), 32'(bclk), 32'(ev[0] & act));
    end

    // Test 6: asynchronous reset between edges in the second half of a bit.
    idle_load(16'd4, 4'd0);
    en = 1'b1;
    for (int e = 0; e <= 40; e++) step();
    chk("t6_pre_bclk", 32'(bclk), 32'd1);
    chk("t6_pre_tick", 32'(tick), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_tick", 32'(tick), 32'd0);
    chk("t6_async_bclk", 32'(bclk), 32'd0);
    chk("t6_async_mid",  32'(mid),  32'd0);
    chk("t6_async_bit",  32'(bstb), 32'd0);
    #1;
    rst = 1'b0;
    for (int e = 0; e <= 40; e++) begin
      step();
      chk($sformatf("t6_tick@%0d", e), 32'(tick), 32'((e > 0) && (e % 16 == 0)));
      chk($sformatf("t6_bad@%0d", e),  32'(bad),  32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
